div_clz_radix2: RTL

// - Radix-2 restoring unsigned divider. Sits behind the divider modport of unsigned_division_interface and serves the div unit (requester).
// - Uses the requester-supplied leading-zero counts to skip guaranteed-zero quotient bits, so latency scales with the dividend/divisor magnitude gap.
// - Result is returned with a single-cycle done pulse.

---
 rtl/div_clz_radix2_pkg.sv | 16 +
 rtl/div_clz_radix2_step.sv | 27 ++
 rtl/div_clz_radix2.sv | 99 +++++++++
 3 files changed

// File: rtl/div_clz_radix2_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// div_clz_radix2_pkg : shared types for the CLZ-skipping divider
// rev 1.0
// ------------------------------------------------------------------
package div_clz_radix2_pkg;

  localparam int c_DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/div_clz_radix2_step.sv
`default_nettype none
// ------------------------------------------------------------------
// div_clz_radix2_step : one restoring compare/subtract/shift iteration
// rev 1.0
// ------------------------------------------------------------------
module div_clz_radix2_step
  import div_clz_radix2_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_rem,
  input  logic [DATA_WIDTH-1:0] i_d,
  input  logic [DATA_WIDTH-1:0] i_q,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic [DATA_WIDTH-1:0] o_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic w_ge;

  assign w_ge  = (i_rem >= i_d);
  assign o_rem = w_ge ? (i_rem - i_d) : i_rem;
  assign o_q   = {i_q[DATA_WIDTH-2:0], w_ge};
  assign o_d   = i_d >> 1;

endmodule
`default_nettype wire

// File: rtl/div_clz_radix2.sv
`default_nettype none
// ------------------------------------------------------------------
// div_clz_radix2 : radix-2 restoring unsigned divider, CLZ-aligned start
// rev 1.0
// ------------------------------------------------------------------
module div_clz_radix2
  import div_clz_radix2_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
  parameter int CLZW       = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [CLZW-1:0]       i_dividend_clz,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  input  logic [CLZW-1:0]       i_divisor_clz,
  input  logic                  i_divisor_is_zero,
  output logic [DATA_WIDTH-1:0] o_quotient,
  output logic [DATA_WIDTH-1:0] o_remainder,
  output logic                  o_done
);

  div_state_e            r_state;
  logic [CLZW-1:0]       r_cnt;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_d;
  logic [DATA_WIDTH-1:0] r_q;

  logic [DATA_WIDTH-1:0] w_rem_nxt;
  logic [DATA_WIDTH-1:0] w_d_nxt;
  logic [DATA_WIDTH-1:0] w_q_nxt;
  logic [CLZW-1:0]       w_shift;
  logic                  w_early;

  // Divisor with fewer leading zeros than the dividend cannot fit even once.
  assign w_early = i_divisor_is_zero || (i_dividend == '0) ||
                   (i_divisor_clz < i_dividend_clz);
  assign w_shift = i_divisor_clz - i_dividend_clz;

  div_clz_radix2_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .i_rem (r_rem),
    .i_d   (r_d),
    .i_q   (r_q),
    .o_rem (w_rem_nxt),
    .o_d   (w_d_nxt),
    .o_q   (w_q_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_d         <= '0;
      r_q         <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_done      <= 1'b0;
    end else begin
      o_done <= 1'b0;

      if (r_state == ST_RUN) begin
        r_rem <= w_rem_nxt;
        r_d   <= w_d_nxt;
        r_q   <= w_q_nxt;
        r_cnt <= r_cnt - CLZW'(1);
        if (r_cnt == '0) begin
          o_quotient  <= w_q_nxt;
          o_remainder <= w_rem_nxt;
          o_done      <= 1'b1;
          r_state     <= ST_IDLE;
        end
      end

      // A new request overrides any iteration in flight.
      if (i_start) begin
        if (w_early) begin
          o_quotient  <= i_divisor_is_zero ? '1 : '0;
          o_remainder <= i_divisor_is_zero ? i_dividend :
                         ((i_dividend == '0) ? '0 : i_dividend);
          o_done      <= 1'b1;
          r_state     <= ST_IDLE;
        end else begin
          r_rem   <= i_dividend;
          r_d     <= i_divisor << w_shift;
          r_q     <= '0;
          r_cnt   <= w_shift;
          r_state <= ST_RUN;
        end
      end
    end
  end

endmodule
`default_nettype wire
